control_antirrebotes: RTL and testbench
=======================================

Name: control_antirrebotes

Overview:
- Scheduler that shares one 6-sample debounce engine among N push-buttons.
- Buttons are sampled round-robin, one per sample tick. Each button keeps a 6-deep history and a stable state.
- Debounced rising edges are queued as pending events and handed to the consumer through a valid/ack handshake with round-robin arbitration.
- Sits between the raw board buttons and the control FSMs, replacing per-button debouncer instances.

Parameters:
- N, 4, number of buttons (2..8)
- TICK_DIV, 50000, clk cycles per sample tick (>=2)
- ID_W, 2, width of the event index; must satisfy 2^ID_W >= N

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- botones  input  N  raw asynchronous button levels
- estado_estable  output  N  debounced level per button
- evento_valido  output  1  a pending event is offered
- evento_id  output  ID_W  index of the offered button
- evento_ack  input  1  consumer accepts the offered event
- evento_perdido  output  1  one-cycle pulse when a new edge hits an already-pending button

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values:
  - prescaler = 0, scan_idx = 0
  - all histories = 0, estado_estable = 0
  - pending = 0, last_grant = N-1
  - FSM = IDLE, evento_valido = 0, evento_id = 0, evento_perdido = 0
- Reset mid-operation discards all pending events and any offer in progress.
- Synchronizer: each botones bit passes through 2 flops before use (2-cycle latency); the flops reset to 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when the count equals TICK_DIV-1.
  - First tick falls on cycle TICK_DIV after reset deasserts.
- Scan:
  - On tick, the synchronized bit of button scan_idx shifts into history[scan_idx] (6 bits, newest at LSB).
  - scan_idx then increments; it wraps from N-1 to 0.
  - Only one button updates per tick; the other histories hold.
- Stable update, in the cycle after the history shift, for that button only:
  - history all 1 -> estado_estable = 1
  - history all 0 -> estado_estable = 0
  - otherwise the stable state holds.
- Worst-case debounce latency = 2 + 6·N·TICK_DIV cycles.
- Event generation:
  - A 0->1 transition of estado_estable[i] sets pending[i].
  - Falling transitions generate nothing.
  - If pending[i] is already set and is not being cleared in the same cycle, the edge is coalesced and evento_perdido pulses for 1 cycle.
  - If the same cycle both sets pending[i] (new edge) and clears it (ack), set wins: pending[i] stays 1 and no loss is flagged.
- Output FSM:
  - IDLE:
    - If pending != 0, select the first set bit searching from last_grant+1 upward, wrapping modulo N.
    - Register the selection into evento_id and go to OFRECE; evento_valido = 1 from the next cycle.
  - OFRECE:
    - evento_valido = 1, and evento_id is held stable.
    - On evento_ack = 1: clear pending[evento_id], set last_grant = evento_id, go to IDLE, and drop evento_valido the next cycle.
    - Without ack, stay in OFRECE indefinitely; new pending bits do not preempt the offer.
  - evento_ack while in IDLE is ignored.
  - Throughput: at most one event per 2 cycles.

Test Plan:
- Reset, then idle (N=4, TICK_DIV=4, botones=0) for 200 cycles -> estado_estable=0, evento_valido=0, evento_perdido=0 throughout.
- botones[1] goes to 1 and stays there -> estado_estable[1]=1 within 2+96 cycles. Then evento_valido=1 with evento_id=1; ack -> evento_valido=0 on the next cycle and no further event.
- Bounce: botones[2] toggles every 8 cycles for 120 cycles, then holds at 1 -> no event during bouncing; exactly one event with id=2 after settling.
- Buttons 0, 2 and 3 all pending with last_grant=N-1 and ack held at 1 -> ids issued in order 0, 2, 3, each 2 cycles apart. A later event on button 0 with last_grant=3 is issued before button 2 when both are pending.
- Button 3 pending with no ack; release and press it again (each held ≥ 96 cycles) -> evento_perdido pulses once; after ack only one id=3 event has been delivered.
- Reset asserted for 1 cycle while evento_valido=1 with 2 events pending -> next cycle evento_valido=0, pending cleared, estado_estable=0; no events until new presses.

Source files
------------

// File: rtl/control_antirrebotes_if.sv
// Button/event bundle between the shared debouncer (master) and its consumer (slave).
// The master drives the debounced levels and the valid/id/lost signals; the slave drives raw levels and ack.
interface control_antirrebotes_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    botones;
    logic [N-1:0]    estado_estable;
    logic            evento_valido;
    logic [ID_W-1:0] evento_id;
    logic            evento_ack;
    logic            evento_perdido;

    modport master (
        input  botones, evento_ack,
        output estado_estable, evento_valido, evento_id, evento_perdido
    );

    modport slave (
        output botones, evento_ack,
        input  estado_estable, evento_valido, evento_id, evento_perdido
    );
endinterface

// File: rtl/control_antirrebotes.sv
// Round-robin 6-sample debouncer shared by N buttons, with a pending-event queue and a valid/ack port.
// Latency up to 2 + 6*N*TICK_DIV cycles; an offer is held until ack, one event per 2 cycles at most.
module control_antirrebotes #(
    parameter int N        = 4,
    parameter int TICK_DIV = 50000,
    parameter int ID_W     = 2
) (
    input logic                    clk,
    input logic                    reset,
    control_antirrebotes_if.master bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, OFRECE} state_t;

    logic [N-1:0]    sync1, sync2;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic [ID_W-1:0] scan_idx, upd_idx;
    logic            upd_vld;
    logic [5:0]      hist [N];
    logic [N-1:0]    estado, pending, stable_nxt, rise, clr;
    logic [ID_W-1:0] last_grant, offer_id, sel, cand;
    logic            sel_vld;
    logic            valido, perdido;
    state_t          state;

    assign tick = (prescaler == PW'(TICK_DIV - 1));

    // The stable state only moves for the button whose history was shifted on the previous tick.
    always_comb begin
        stable_nxt = estado;
        if (upd_vld) begin
            if (&hist[upd_idx]) begin
                stable_nxt[upd_idx] = 1'b1;
            end else if (~|hist[upd_idx]) begin
                stable_nxt[upd_idx] = 1'b0;
            end
        end
    end

    assign rise = stable_nxt & ~estado;

    always_comb begin
        clr = '0;
        if (state == OFRECE && bus.evento_ack) begin
            clr[offer_id] = 1'b1;
        end
    end

    // First pending button after the last one granted, wrapping modulo N.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N);
            if (!sel_vld && pending[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            prescaler <= '0;
            scan_idx  <= '0;
            upd_idx   <= '0;
            upd_vld   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            estado    <= '0;
            pending   <= '0;
            perdido   <= 1'b0;
        end else begin
            sync1     <= bus.botones;
            sync2     <= sync1;
            prescaler <= tick ? '0 : prescaler + 1'b1;
            upd_vld   <= tick;
            if (tick) begin
                hist[scan_idx] <= {hist[scan_idx][4:0], sync2[scan_idx]};
                upd_idx        <= scan_idx;
                scan_idx       <= (scan_idx == ID_W'(N - 1)) ? '0 : scan_idx + 1'b1;
            end
            estado  <= stable_nxt;
            // A new edge wins over a same-cycle ack, so it is never reported as lost.
            pending <= (pending & ~clr) | rise;
            perdido <= |(rise & pending & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valido     <= 1'b0;
            offer_id   <= '0;
            last_grant <= ID_W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        offer_id <= sel;
                        valido   <= 1'b1;
                        state    <= OFRECE;
                    end
                end
                OFRECE: begin
                    if (bus.evento_ack) begin
                        last_grant <= offer_id;
                        valido     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.estado_estable = estado;
    assign bus.evento_valido  = valido;
    assign bus.evento_id      = offer_id;
    assign bus.evento_perdido = perdido;
endmodule

// File: tb/tb_control_antirrebotes.sv
// Directed and randomized bench for the shared debouncer, checked every cycle against a run-length model.
`timescale 1ns/1ps
module tb_control_antirrebotes;
    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_antirrebotes_if #(.N(N), .ID_W(ID_W)) bus ();

    control_antirrebotes #(.N(N), .TICK_DIV(TD), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nchk = 0;
    int npass = 0;

    // Reference model: run lengths of equal samples per button, sample time from edge count.
    logic [N-1:0] m_q0, m_q1, m_stable, m_pend;
    int  run1 [N];
    int  run0 [N];
    int  ecount, m_upd_idx, m_id, m_last;
    bit  m_upd, m_offer, m_lost;

    bit  acc_now;
    int  acc_id;
    int  c_id [3];
    int  c_t  [3];
    int  c_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_q0 = '0; m_q1 = '0; m_stable = '0; m_pend = '0;
        ecount = 0; m_upd = 1'b0; m_upd_idx = 0;
        m_offer = 1'b0; m_id = 0; m_last = N - 1; m_lost = 1'b0;
        for (int i = 0; i < N; i++) begin
            run1[i] = 0;
            run0[i] = 6;
        end
    endtask

    task automatic m_edge(input logic [N-1:0] b, input logic r, input logic a);
        logic [N-1:0] nstable, rs, cl;
        int e, btn;
        if (r) begin
            m_reset();
            return;
        end
        e = ecount + 1;
        nstable = m_stable;
        if (m_upd) begin
            if (run1[m_upd_idx] >= 6) nstable[m_upd_idx] = 1'b1;
            else if (run0[m_upd_idx] >= 6) nstable[m_upd_idx] = 1'b0;
        end
        rs = nstable & ~m_stable;
        cl = '0;
        if (m_offer && a) cl[m_id] = 1'b1;
        m_lost = |(rs & m_pend & ~cl);
        if (m_offer && a) begin
            m_offer = 1'b0;
            m_last  = m_id;
        end else if (!m_offer && m_pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_offer && m_pend[(m_last + k) % N]) begin
                    m_offer = 1'b1;
                    m_id    = (m_last + k) % N;
                end
            end
        end
        m_pend   = (m_pend & ~cl) | rs;
        m_stable = nstable;
        m_upd    = (e % TD == 0);
        if (m_upd) begin
            btn = (e / TD - 1) % N;
            if (m_q1[btn]) begin
                run1[btn]++;
                run0[btn] = 0;
            end else begin
                run0[btn]++;
                run1[btn] = 0;
            end
            m_upd_idx = btn;
        end
        m_q1 = m_q0;
        m_q0 = b;
        ecount = e;
    endtask

    task automatic step();
        logic [N-1:0] b;
        logic r, a;
        b = bus.botones;
        r = reset;
        a = bus.evento_ack;
        acc_now = bus.evento_valido && a;
        acc_id  = int'(bus.evento_id);
        @(posedge clk);
        m_edge(b, r, a);
        @(negedge clk);
        chk("estado_estable", 32'(bus.estado_estable), 32'(m_stable));
        chk("evento_valido",  32'(bus.evento_valido),  32'(m_offer));
        chk("evento_id",      32'(bus.evento_id),      32'(m_id));
        chk("evento_perdido", 32'(bus.evento_perdido), 32'(m_lost));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget, input string tag);
        for (int i = 0; i < budget && !bus.evento_valido; i++) step();
        chk(tag, 32'(bus.evento_valido), 32'd1);
    endtask

    task automatic collect3(input int budget);
        c_n = 0;
        for (int i = 0; i < 3; i++) begin
            c_id[i] = -1;
            c_t[i]  = -1;
        end
        for (int i = 1; i <= budget && c_n < 3; i++) begin
            step();
            if (acc_now) begin
                c_id[c_n] = acc_id;
                c_t[c_n]  = i;
                c_n++;
            end
        end
    endtask

    initial begin
        int lat, n_a, n_b, n_perd, idx;

        reset = 1'b1;
        bus.botones = '0;
        bus.evento_ack = 1'b0;
        run(3);
        chk("rst_estado",  32'(bus.estado_estable), 32'd0);
        chk("rst_valido",  32'(bus.evento_valido),  32'd0);
        chk("rst_id",      32'(bus.evento_id),      32'd0);
        chk("rst_perdido", 32'(bus.evento_perdido), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            step();
            chk("idle_valido", 32'(bus.evento_valido), 32'd0);
        end

        // Single clean press on button 1.
        bus.botones[1] = 1'b1;
        lat = 0;
        while (!bus.estado_estable[1] && lat < 120) begin
            step();
            lat++;
        end
        chk("deb_latency_le_98", 32'(lat <= 98), 32'd1);
        wait_valid(10, "ev1_valido");
        chk("ev1_id", 32'(bus.evento_id), 32'd1);
        bus.evento_ack = 1'b1;
        step();
        bus.evento_ack = 1'b0;
        chk("ev1_drop", 32'(bus.evento_valido), 32'd0);
        n_a = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (bus.evento_valido) n_a++;
        end
        chk("ev1_no_more", 32'(n_a), 32'd0);

        // Bouncing button 2 with a randomly acking consumer.
        n_a = 0; n_b = 0;
        for (int i = 0; i < 120; i++) begin
            if (i % 8 == 0) bus.botones[2] = ~bus.botones[2];
            bus.evento_ack = 1'($urandom_range(0, 1));
            step();
            if (acc_now) begin
                if (acc_id == 2) n_a++; else n_b++;
            end
        end
        bus.botones[2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.evento_ack = 1'($urandom_range(0, 1));
            step();
            if (acc_now) begin
                if (acc_id == 2) n_a++; else n_b++;
            end
        end
        bus.evento_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (acc_now) begin
                if (acc_id == 2) n_a++; else n_b++;
            end
        end
        bus.evento_ack = 1'b0;
        chk("bounce_one_id2", 32'(n_a), 32'd1);
        chk("bounce_no_other", 32'(n_b), 32'd0);

        // Round-robin order from last_grant = N-1 with ack held high.
        reset = 1'b1;
        bus.botones = '0;
        step();
        reset = 1'b0;
        bus.botones = 4'b1101;
        lat = 0;
        while ((bus.estado_estable & 4'b1101) != 4'b1101 && lat < 150) begin
            step();
            lat++;
        end
        chk("rr_all_stable", 32'(bus.estado_estable & 4'b1101), 32'hd);
        run(2);
        chk("rr_first_offer", 32'(bus.evento_id), 32'd0);
        bus.evento_ack = 1'b1;
        collect3(12);
        bus.evento_ack = 1'b0;
        chk("rr_id0", 32'(c_id[0]), 32'd0);
        chk("rr_id1", 32'(c_id[1]), 32'd2);
        chk("rr_id2", 32'(c_id[2]), 32'd3);
        chk("rr_gap01", 32'(c_t[1] - c_t[0]), 32'd2);
        chk("rr_gap12", 32'(c_t[2] - c_t[1]), 32'd2);

        // With last_grant = 3, button 0 precedes button 2.
        bus.botones = '0;
        run(110);
        bus.botones = 4'b1000;
        wait_valid(120, "rr2_valido");
        chk("rr2_offer3", 32'(bus.evento_id), 32'd3);
        bus.botones = 4'b1101;
        lat = 0;
        while ((bus.estado_estable & 4'b0101) != 4'b0101 && lat < 120) begin
            step();
            lat++;
        end
        run(2);
        bus.evento_ack = 1'b1;
        collect3(12);
        bus.evento_ack = 1'b0;
        chk("rr2_id0", 32'(c_id[0]), 32'd3);
        chk("rr2_id1", 32'(c_id[1]), 32'd0);
        chk("rr2_id2", 32'(c_id[2]), 32'd2);

        // Second edge on an unacked button is coalesced and flagged once.
        bus.botones[3] = 1'b0;
        run(110);
        bus.botones[3] = 1'b1;
        wait_valid(120, "lost_valido");
        chk("lost_offer3", 32'(bus.evento_id), 32'd3);
        n_perd = 0;
        bus.botones[3] = 1'b0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (bus.evento_perdido) n_perd++;
        end
        bus.botones[3] = 1'b1;
        for (int i = 0; i < 110; i++) begin
            step();
            if (bus.evento_perdido) n_perd++;
        end
        chk("lost_once", 32'(n_perd), 32'd1);
        n_a = 0;
        bus.evento_ack = 1'b1;
        step();
        if (acc_now && acc_id == 3) n_a++;
        bus.evento_ack = 1'b0;
        n_b = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.evento_valido) n_b++;
        end
        chk("lost_delivered_once", 32'(n_a), 32'd1);
        chk("lost_no_repeat", 32'(n_b), 32'd0);

        // Reset during an offer with another event pending.
        bus.botones = '0;
        run(110);
        bus.botones = 4'b0110;
        lat = 0;
        while ((bus.estado_estable & 4'b0110) != 4'b0110 && lat < 130) begin
            step();
            lat++;
        end
        run(2);
        chk("mid_pre_valido", 32'(bus.evento_valido), 32'd1);
        reset = 1'b1;
        bus.botones = '0;
        step();
        reset = 1'b0;
        chk("mid_valido", 32'(bus.evento_valido), 32'd0);
        chk("mid_estado", 32'(bus.estado_estable), 32'd0);
        n_b = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (bus.evento_valido) n_b++;
        end
        chk("mid_no_events", 32'(n_b), 32'd0);
        bus.botones = 4'b0001;
        wait_valid(120, "mid_new_press");
        chk("mid_new_id", 32'(bus.evento_id), 32'd0);
        bus.evento_ack = 1'b1;
        step();
        bus.evento_ack = 1'b0;

        // Random presses, bounces, acks and one reset, checked cycle by cycle.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                bus.botones = N'($urandom);
            end else if (i % 150 < 40 && $urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, N - 1);
                bus.botones[idx] = ~bus.botones[idx];
            end
            bus.evento_ack = ($urandom_range(0, 3) == 0);
            reset = (i == 1500);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
